rr_arbiter_8x4: RTL and testbench
=================================

# rr_arbiter_8x4

Round-robin arbiter that shares the 8:1 4-bit mux datapath (`mux4x8to4_c`) among eight requesters. It selects one requester at a time and drives the mux `select`. The selected requester's 4-bit data reaches a registered output for a bounded burst, then the grant rotates to the next requester. It sits between the requesting sources and the single shared 4-bit consumer bus.

## Interface
Parameters:
- `MAX_BURST`, default 4: maximum beats per grant before forced rotation; legal range 1..15.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  8  request vector; bit i means requester i has data.
- `in_0` .. `in_7`  in  4 each  requester data, sampled only while the requester is granted.
- `grant`  out  8  one-hot grant; all zero when idle.
- `select`  out  3  index driven to the mux; holds the last granted index when idle.
- `out`  out  4  registered data beat.
- `out_valid`  out  1  `out` holds a beat accepted on the previous edge.
- `busy`  out  1  FSM is in GRANT.

## Operation
- FSM has two states: IDLE and GRANT. Internal state: 3-bit priority pointer `ptr` and beat counter `cnt` (4 bits).
- Reset values: state IDLE, `grant`=0, `select`=0, `out`=0, `out_valid`=0, `busy`=0, `ptr`=0, `cnt`=0.
- **IDLE, `req`≠0.** The winner is the first set bit scanning `ptr`, `ptr`+1, … with mod-8 wrap.
  - On the edge: `grant` ← onehot(winner), `select` ← winner, `cnt` ← 0, state ← GRANT.
- **IDLE, `req`=0.** Nothing changes except `out_valid` ← 0.
- **GRANT, `req[select]`=1 (beat).**
  - `out` ← `in_[select]` via the mux, `out_valid` ← 1, `cnt` ← `cnt`+1.
  - If `cnt`+1 = `MAX_BURST`: release.
- **GRANT, `req[select]`=0 (drop).** `out_valid` ← 0, then release. No beat is taken.
- **Release.** State ← IDLE, `grant` ← 0, `ptr` ← `select`+1 (mod 8, so 7 wraps to 0).
- `out` holds its last value when `out_valid`=0.
- In GRANT, `req` bits of non-granted requesters are ignored. There is no preemption.
- Arbitration is fair: a continuously requesting requester waits at most 7 grants.

## Timing
- Request to grant: `req` high at edge T in IDLE → `grant`/`select`/`busy` valid after edge T.
- Grant to data: first beat is sampled at edge T+1. `out`/`out_valid` are valid after T+1.
- A full burst occupies `MAX_BURST` GRANT cycles plus one IDLE cycle. This gives one bubble cycle between consecutive grants.
- A drop on the final beat cannot occur: the beat condition requires `req[select]`=1.
- `MAX_BURST`=1: grant, one beat, release. Each grant costs 2 cycles.
- `reset_n` low at any time, including mid-burst:
  - All outputs and state return to reset values immediately (asynchronously).
  - A partially transferred burst is abandoned.
  - First arbitration after reset starts from requester 0.

## Structure
- Shared package `arb_pkg`:
  - state enum (IDLE, GRANT)
  - `N_REQ`=8
  - `SEL_W`=3
  - `DATA_W`=4
  - function `rr_pick(req, ptr)` returning the winner index
- Sub-module: one instance of the existing `mux4x8to4_c`, driven by `select`. Its `out` feeds the `out` register.
- Priority rotation is implemented combinationally: rotate `req` right by `ptr`, priority-encode, then add `ptr` back mod 8.

## Test plan
1. **Reset.** Hold `reset_n`=0 with `req`=8'hFF. Required: `grant`=0, `select`=0, `out_valid`=0, `busy`=0 throughout.
2. **Single full burst.** `MAX_BURST`=4, `in_3`=4'b0011, `req`=8'h08 held.
   - Required: `grant`=8'h08 one cycle after request.
   - 4 beats with `out`=4'b0011.
   - 1 idle cycle, then requester 3 is regranted (sole requester).
3. **Rotation and wrap.** `req`=8'hFF held, `MAX_BURST`=1, `in_i`=i. Required: `select` sequence 0,1,…,7,0 and `out` sequence 0..7,0 on each valid beat.
4. **Two-way fairness.** `req`=8'h24 held, `MAX_BURST`=4. Required: 4 beats from requester 2 (`out`=4'b0010), idle, 4 beats from requester 5, idle, then requester 2.
5. **Drop mid-burst.** Grant to requester 6; deassert `req[6]` after 2 beats. Required: exactly 2 valid beats, release, and `ptr`=7. With `req`=8'h41, requester 0 is granted next (scan 7→0).
6. **Reset mid-burst.** Pulse `reset_n` low during beat 2 of a grant to requester 4. Required: outputs cleared immediately. After release of reset with `req`=8'h11, requester 0 is granted first.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types, widths and the rotating-priority pick used by the 8-way arbiter.
package arb_pkg;

    typedef enum logic {ST_IDLE, ST_GRANT} state_t;

    localparam int N_REQ  = 8;
    localparam int SEL_W  = 3;
    localparam int DATA_W = 4;

    // Rotate so ptr lands at bit 0, take the lowest set bit, then undo the rotation.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [SEL_W-1:0] ptr);
        logic [2*N_REQ-1:0] dbl;
        logic [N_REQ-1:0]   rot;
        logic [SEL_W-1:0]   idx;
        dbl = {req, req};
        rot = N_REQ'(dbl >> ptr);
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) idx = SEL_W'(i);
        end
        return idx + ptr;
    endfunction

endpackage

// File: rtl/mux4x8to4_c.sv
// 8:1 multiplexer of 4-bit requester data, steered by the arbiter's select.
module mux4x8to4_c
    import arb_pkg::*;
(
    input  logic [SEL_W-1:0]  select,
    input  logic [DATA_W-1:0] in_0,
    input  logic [DATA_W-1:0] in_1,
    input  logic [DATA_W-1:0] in_2,
    input  logic [DATA_W-1:0] in_3,
    input  logic [DATA_W-1:0] in_4,
    input  logic [DATA_W-1:0] in_5,
    input  logic [DATA_W-1:0] in_6,
    input  logic [DATA_W-1:0] in_7,
    output logic [DATA_W-1:0] out
);

    always_comb begin
        case (select)
            3'd0:    out = in_0;
            3'd1:    out = in_1;
            3'd2:    out = in_2;
            3'd3:    out = in_3;
            3'd4:    out = in_4;
            3'd5:    out = in_5;
            3'd6:    out = in_6;
            default: out = in_7;
        endcase
    end

endmodule

// File: rtl/rr_arbiter_8x4.sv
// Round-robin arbiter granting the shared 4-bit mux to one of eight requesters
// for bursts of up to MAX_BURST beats, with a registered output beat.
module rr_arbiter_8x4
    import arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_REQ-1:0]  req,
    input  logic [DATA_W-1:0] in_0,
    input  logic [DATA_W-1:0] in_1,
    input  logic [DATA_W-1:0] in_2,
    input  logic [DATA_W-1:0] in_3,
    input  logic [DATA_W-1:0] in_4,
    input  logic [DATA_W-1:0] in_5,
    input  logic [DATA_W-1:0] in_6,
    input  logic [DATA_W-1:0] in_7,
    output logic [N_REQ-1:0]  grant,
    output logic [SEL_W-1:0]  select,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              busy
);

    localparam logic [3:0] BURST = 4'(MAX_BURST);

    state_t            r_state, w_state_nxt;
    logic [SEL_W-1:0]  r_ptr;
    logic [3:0]        r_cnt;
    logic [N_REQ-1:0]  r_grant;
    logic [SEL_W-1:0]  r_select;
    logic [DATA_W-1:0] r_out;
    logic              r_out_valid;

    logic [SEL_W-1:0]  w_winner;
    logic [DATA_W-1:0] w_mux_out;
    logic [3:0]        w_cnt_inc;
    logic              w_beat;
    logic              w_release;

    mux4x8to4_c u_mux (
        .select (r_select),
        .in_0   (in_0),
        .in_1   (in_1),
        .in_2   (in_2),
        .in_3   (in_3),
        .in_4   (in_4),
        .in_5   (in_5),
        .in_6   (in_6),
        .in_7   (in_7),
        .out    (w_mux_out)
    );

    assign w_winner  = rr_pick(req, r_ptr);
    assign w_cnt_inc = r_cnt + 4'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_beat      = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|req) w_state_nxt = ST_GRANT;
            end
            ST_GRANT: begin
                // Only the granted requester's bit matters; others wait their turn.
                w_beat    = req[r_select];
                w_release = !w_beat || (w_cnt_inc == BURST);
                if (w_release) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_grant     <= '0;
            r_select    <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            r_out_valid <= 1'b0;
            if (|req) begin
                r_grant  <= N_REQ'(1) << w_winner;
                r_select <= w_winner;
                r_cnt    <= '0;
            end
        end else begin
            r_out_valid <= w_beat;
            if (w_beat) begin
                r_out <= w_mux_out;
                r_cnt <= w_cnt_inc;
            end
            if (w_release) begin
                r_grant <= '0;
                r_ptr   <= r_select + 3'd1;
            end
        end
    end

    assign grant     = r_grant;
    assign select    = r_select;
    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign busy      = (r_state == ST_GRANT);

endmodule

// File: tb/tb_rr_arbiter_8x4.sv
// Directed bench for rr_arbiter_8x4: one instance with 4-beat bursts, one with 1-beat.
module tb_rr_arbiter_8x4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] req = '0;
    logic [3:0] in_d [8];

    logic [7:0] grant_a, grant_b;
    logic [2:0] select_a, select_b;
    logic [3:0] out_a, out_b;
    logic       ov_a, ov_b, busy_a, busy_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rr_arbiter_8x4 #(.MAX_BURST(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .req(req),
        .in_0(in_d[0]), .in_1(in_d[1]), .in_2(in_d[2]), .in_3(in_d[3]),
        .in_4(in_d[4]), .in_5(in_d[5]), .in_6(in_d[6]), .in_7(in_d[7]),
        .grant(grant_a), .select(select_a), .out(out_a),
        .out_valid(ov_a), .busy(busy_a)
    );

    rr_arbiter_8x4 #(.MAX_BURST(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .req(req),
        .in_0(in_d[0]), .in_1(in_d[1]), .in_2(in_d[2]), .in_3(in_d[3]),
        .in_4(in_d[4]), .in_5(in_d[5]), .in_6(in_d[6]), .in_7(in_d[7]),
        .grant(grant_b), .select(select_b), .out(out_b),
        .out_valid(ov_b), .busy(busy_b)
    );

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        req     = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [16:0] got;
        for (int i = 0; i < 8; i++) in_d[i] = 4'hF;
        @(negedge clk);
        reset_n = 1'b0;
        req     = 8'hFF;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            got = {grant_a, select_a, out_a, ov_a, busy_a};
            n_checks++;
            if (got !== 17'h0) begin
                n_errors++;
                $display("FAIL reset_a got %h exp %h", got, 17'h0);
            end
            got = {grant_b, select_b, out_b, ov_b, busy_b};
            n_checks++;
            if (got !== 17'h0) begin
                n_errors++;
                $display("FAIL reset_b got %h exp %h", got, 17'h0);
            end
        end
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({grant_a, select_a} !== {8'h01, 3'd0}) begin
            n_errors++;
            $display("FAIL reset_first_pick got %h/%0d exp 01/0", grant_a, select_a);
        end
    endtask

    task automatic test_burst();
        do_reset();
        in_d[3] = 4'b0011;
        req     = 8'h08;
        @(negedge clk);
        n_checks++;
        if ({grant_a, select_a, busy_a, ov_a} !== {8'h08, 3'd3, 1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL burst_grant got %h/%0d/%b/%b exp 08/3/1/0", grant_a, select_a, busy_a, ov_a);
        end
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            n_checks++;
            if ({ov_a, out_a} !== 5'h13) begin
                n_errors++;
                $display("FAIL burst_beat%0d got %b/%h exp 1/3", b, ov_a, out_a);
            end
        end
        n_checks++;
        if ({grant_a, busy_a} !== 9'h0) begin
            n_errors++;
            $display("FAIL burst_release got %h/%b exp 00/0", grant_a, busy_a);
        end
        @(negedge clk);
        n_checks++;
        if ({grant_a, ov_a} !== {8'h08, 1'b0}) begin
            n_errors++;
            $display("FAIL burst_regrant got %h/%b exp 08/0", grant_a, ov_a);
        end
        req = '0;
    endtask

    task automatic test_rotation();
        logic [7:0] eg;
        logic [2:0] es;
        do_reset();
        for (int i = 0; i < 8; i++) in_d[i] = 4'(i);
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            es = 3'(k % 8);
            eg = 8'h01 << es;
            @(negedge clk);
            n_checks++;
            if ({grant_b, select_b, ov_b} !== {eg, es, 1'b0}) begin
                n_errors++;
                $display("FAIL rot_grant%0d got %h/%0d/%b exp %h/%0d/0", k, grant_b, select_b, ov_b, eg, es);
            end
            @(negedge clk);
            n_checks++;
            if ({ov_b, out_b} !== {1'b1, 1'b0, es}) begin
                n_errors++;
                $display("FAIL rot_beat%0d got %b/%h exp 1/%h", k, ov_b, out_b, es);
            end
        end
        req = '0;
    endtask

    task automatic test_fairness();
        do_reset();
        in_d[2] = 4'b0010;
        in_d[5] = 4'b0101;
        req     = 8'h24;
        @(negedge clk);
        n_checks++;
        if (grant_a !== 8'h04) begin
            n_errors++;
            $display("FAIL fair_g2 got %h exp 04", grant_a);
        end
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            n_checks++;
            if ({ov_a, out_a} !== 5'h12) begin
                n_errors++;
                $display("FAIL fair_r2_beat%0d got %b/%h exp 1/2", b, ov_a, out_a);
            end
        end
        n_checks++;
        if ({grant_a, busy_a} !== 9'h0) begin
            n_errors++;
            $display("FAIL fair_bubble got %h/%b exp 00/0", grant_a, busy_a);
        end
        @(negedge clk);
        n_checks++;
        if ({grant_a, select_a, ov_a} !== {8'h20, 3'd5, 1'b0}) begin
            n_errors++;
            $display("FAIL fair_g5 got %h/%0d/%b exp 20/5/0", grant_a, select_a, ov_a);
        end
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            n_checks++;
            if ({ov_a, out_a} !== 5'h15) begin
                n_errors++;
                $display("FAIL fair_r5_beat%0d got %b/%h exp 1/5", b, ov_a, out_a);
            end
        end
        @(negedge clk);
        n_checks++;
        if (grant_a !== 8'h04) begin
            n_errors++;
            $display("FAIL fair_back_to_2 got %h exp 04", grant_a);
        end
        req = '0;
    endtask

    task automatic test_drop();
        do_reset();
        in_d[6] = 4'b0110;
        req     = 8'h40;
        @(negedge clk);
        n_checks++;
        if (grant_a !== 8'h40) begin
            n_errors++;
            $display("FAIL drop_grant got %h exp 40", grant_a);
        end
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            n_checks++;
            if ({ov_a, out_a} !== 5'h16) begin
                n_errors++;
                $display("FAIL drop_beat%0d got %b/%h exp 1/6", b, ov_a, out_a);
            end
        end
        req = 8'h00;
        @(negedge clk);
        n_checks++;
        if ({ov_a, grant_a, busy_a, out_a} !== {1'b0, 8'h00, 1'b0, 4'h6}) begin
            n_errors++;
            $display("FAIL drop_release got %b/%h/%b/%h exp 0/00/0/6", ov_a, grant_a, busy_a, out_a);
        end
        req = 8'h41;
        @(negedge clk);
        n_checks++;
        if ({grant_a, select_a} !== {8'h01, 3'd0}) begin
            n_errors++;
            $display("FAIL drop_next got %h/%0d exp 01/0", grant_a, select_a);
        end
        req = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_d[4] = 4'b0100;
        req     = 8'h10;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({grant_a, ov_a, out_a} !== {8'h10, 1'b1, 4'h4}) begin
            n_errors++;
            $display("FAIL rmid_beat1 got %h/%b/%h exp 10/1/4", grant_a, ov_a, out_a);
        end
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({grant_a, select_a, out_a, ov_a, busy_a} !== 17'h0) begin
            n_errors++;
            $display("FAIL rmid_async got %h/%0d/%h/%b/%b exp all zero", grant_a, select_a, out_a, ov_a, busy_a);
        end
        @(negedge clk);
        req     = 8'h11;
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({grant_a, select_a} !== {8'h01, 3'd0}) begin
            n_errors++;
            $display("FAIL rmid_first got %h/%0d exp 01/0", grant_a, select_a);
        end
        req = '0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) in_d[i] = '0;
        test_reset();
        test_burst();
        test_rotation();
        test_fairness();
        test_drop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
